// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge
//   Wishbone slave front-end for a small UART register file. Every Wishbone
//   input is registered into a capture stage. A six-state FSM then issues one
//   single-cycle register strobe and terminates the bus cycle. It terminates
//   with ack after WAIT_STATES optional wait cycles, or with err when the byte
//   select is unsupported.
//
// Ports
//   clk, wb_rst_n_i              clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i          Wishbone cycle, strobe, write enable
//   wb_adr_i [AW]                register address
//   wb_sel_i [DW/8]              byte-lane select
//   wb_dat_i [DW] / wb_dat_o [DW] write data in / registered read data out
//   wb_ack_o, wb_err_o           single-cycle normal / error termination
//   reg_adr_o [AW]               register-file address
//   reg_we_o, reg_re_o           single-cycle register write / read strobes
//   reg_wide_o                   current access is a full 32-bit word
//   reg_dat8_o, reg_dat32_o      write data to the register file
//   reg_dat8_i, reg_dat32_i      combinational read data for reg_adr_o
module uart_wb_bridge #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            wb_rst_n_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic [AW-1:0]   reg_adr_o,
    output logic            reg_we_o,
    output logic            reg_re_o,
    output logic            reg_wide_o,
    output logic [7:0]      reg_dat8_o,
    output logic [31:0]     reg_dat32_o,
    input  logic [7:0]      reg_dat8_i,
    input  logic [31:0]     reg_dat32_i
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        ACK,
        ERR,
        RECOVER
    } state_t;

    state_t state, next_state;

    // capture stage
    logic            cyc_s, stb_s, we_s;
    logic [AW-1:0]   adr_s;
    logic [DW/8-1:0] sel_s;
    logic [DW-1:0]   dat_s;

    logic [3:0]  wait_cnt;
    logic [1:0]  lane_q;
    logic        rd_q;

    logic [3:0]  sel4;
    logic        sel_valid;
    logic        wide_s;
    logic [1:0]  lane_s;
    logic [31:0] dat32_s;
    logic [31:0] rd_word;
    logic        enter_access;

    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cyc_s <= 1'b0;
            stb_s <= 1'b0;
            we_s  <= 1'b0;
            adr_s <= '0;
            sel_s <= '0;
            dat_s <= '0;
        end else begin
            cyc_s <= wb_cyc_i;
            stb_s <= wb_stb_i;
            we_s  <= wb_we_i;
            adr_s <= wb_adr_i;
            sel_s <= wb_sel_i;
            dat_s <= wb_dat_i;
        end
    end

    // An 8-bit bus always addresses lane 0. Widening sel to four lanes lets
    // both bus widths share one decoder.
    always_comb begin
        sel4    = (DW == 32) ? 4'(sel_s) : 4'b0001;
        dat32_s = 32'(dat_s);
        wide_s  = (DW == 32) && (sel4 == 4'b1111);
        sel_valid = 1'b0;
        lane_s    = 2'd0;
        case (sel4)
            4'b0001: begin sel_valid = 1'b1; lane_s = 2'd0; end
            4'b0010: begin sel_valid = 1'b1; lane_s = 2'd1; end
            4'b0100: begin sel_valid = 1'b1; lane_s = 2'd2; end
            4'b1000: begin sel_valid = 1'b1; lane_s = 2'd3; end
            4'b1111: begin sel_valid = 1'b1; lane_s = 2'd0; end
            default: begin sel_valid = 1'b0; lane_s = 2'd0; end
        endcase
    end

    always_comb begin
        next_state   = state;
        enter_access = 1'b0;
        case (state)
            IDLE: begin
                if (cyc_s && stb_s) begin
                    if (sel_valid) begin
                        next_state   = ACCESS;
                        enter_access = 1'b1;
                    end else begin
                        next_state = ERR;
                    end
                end
            end
            ACCESS: begin
                if (!cyc_s)               next_state = RECOVER;
                else if (WAIT_STATES > 0) next_state = WAIT;
                else                      next_state = ACK;
            end
            WAIT: begin
                if (!cyc_s)              next_state = RECOVER;
                else if (wait_cnt == '0) next_state = ACK;
            end
            ACK:     next_state = RECOVER;
            ERR:     next_state = RECOVER;
            RECOVER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Byte reads are returned in the lane they were requested on.
    always_comb begin
        rd_word = reg_wide_o ? reg_dat32_i : ({24'd0, reg_dat8_i} << {lane_q, 3'b000});
    end

    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wait_cnt    <= '0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= '0;
            reg_adr_o   <= '0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            reg_wide_o  <= 1'b0;
            reg_dat8_o  <= '0;
            reg_dat32_o <= '0;
            lane_q      <= '0;
            rd_q        <= 1'b0;
        end else begin
            // Terminations are registered copies of the next state, so they
            // coincide exactly with the ACK / ERR state cycles.
            wb_ack_o <= (next_state == ACK);
            wb_err_o <= (next_state == ERR);
            reg_we_o <= enter_access && we_s;
            reg_re_o <= enter_access && !we_s;

            if (state == ACCESS) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (enter_access) begin
                reg_adr_o   <= adr_s;
                reg_wide_o  <= wide_s;
                reg_dat8_o  <= dat32_s[{lane_s, 3'b000} +: 8];
                reg_dat32_o <= dat32_s;
                lane_q      <= lane_s;
                rd_q        <= !we_s;
            end

            // Read data is sampled at the end of ACCESS even if the cycle is
            // being aborted; the read strobe has already been issued.
            if (state == ACCESS && rd_q) begin
                wb_dat_o <= rd_word[DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge. Three instances (WAIT_STATES 0, 3 and 5) each
// have their own bus. A small register-file model supplies read data, and
// expected bus timing follows the cycle-count rules of the bridge.
module tb_uart_wb_bridge;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        cyc   [N];
    logic        stb   [N];
    logic        we    [N];
    logic [4:0]  adr   [N];
    logic [3:0]  sel   [N];
    logic [31:0] dat   [N];
    logic [31:0] dato  [N];
    logic        ack   [N];
    logic        err   [N];
    logic [4:0]  radr  [N];
    logic        rwe   [N];
    logic        rre   [N];
    logic        rwide [N];
    logic [7:0]  rd8o  [N];
    logic [31:0] rd32o [N];
    logic [7:0]  rd8i  [N];
    logic [31:0] rd32i [N];

    logic [7:0]  mem8    [32];
    logic [31:0] mem32   [32];
    logic [31:0] prev_rd [N];
    logic [3:0]  bad_sel [11];

    int vectors = 0;
    int miss    = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int WSG = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        uart_wb_bridge #(.DW(32), .AW(5), .WAIT_STATES(WSG)) u_dut (
            .clk        (clk),
            .wb_rst_n_i (rst_n),
            .wb_cyc_i   (cyc[g]),
            .wb_stb_i   (stb[g]),
            .wb_we_i    (we[g]),
            .wb_adr_i   (adr[g]),
            .wb_sel_i   (sel[g]),
            .wb_dat_i   (dat[g]),
            .wb_dat_o   (dato[g]),
            .wb_ack_o   (ack[g]),
            .wb_err_o   (err[g]),
            .reg_adr_o  (radr[g]),
            .reg_we_o   (rwe[g]),
            .reg_re_o   (rre[g]),
            .reg_wide_o (rwide[g]),
            .reg_dat8_o (rd8o[g]),
            .reg_dat32_o(rd32o[g]),
            .reg_dat8_i (rd8i[g]),
            .reg_dat32_i(rd32i[g])
        );
        assign rd8i[g]  = mem8[radr[g]];
        assign rd32i[g] = mem32[radr[g]];
    end

    // One transfer on instance k, starting just after a rising edge (cycle 0).
    // drop > 0 releases cyc/stb at the start of that cycle.
    task automatic run_xfer(input int k, input bit w, input logic [4:0] a,
                            input logic [3:0] s, input logic [31:0] d, input int drop);
        int          wt, lane, last;
        bit          valid, wide, aborted;
        logic [31:0] exp_rd, exp_dat;
        logic [7:0]  exp_b;
        logic [3:0]  exp_hs, got_hs;
        wt      = ws_of(k);
        wide    = (s == 4'hF);
        valid   = wide || s == 4'h1 || s == 4'h2 || s == 4'h4 || s == 4'h8;
        lane    = (s == 4'h2) ? 1 : (s == 4'h4) ? 2 : (s == 4'h8) ? 3 : 0;
        aborted = valid && drop >= 1 && drop <= 1 + wt;
        last    = valid ? 3 + wt : 2;
        exp_rd  = wide ? mem32[a] : ({24'd0, mem8[a]} << (8 * lane));
        exp_b   = d[8 * lane +: 8];
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat[k] = d;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            exp_hs = {valid && !aborted && c == 3 + wt, !valid && c == 2,
                      valid && w && c == 2, valid && !w && c == 2};
            got_hs = {ack[k], err[k], rwe[k], rre[k]};
            vectors++;
            if (got_hs !== exp_hs) begin
                miss++;
                $display("FAIL handshake dut%0d cycle %0d: ack/err/we/re got %b expected %b",
                         k, c, got_hs, exp_hs);
            end
            exp_dat = (valid && !w && c >= 3) ? exp_rd : prev_rd[k];
            vectors++;
            if (dato[k] !== exp_dat) begin
                miss++;
                $display("FAIL rdata dut%0d cycle %0d: got %08h expected %08h",
                         k, c, dato[k], exp_dat);
            end
            if (valid && c == 2) begin
                vectors++;
                if (radr[k] !== a || rwide[k] !== wide) begin
                    miss++;
                    $display("FAIL reg_adr/wide dut%0d: got %0d/%b expected %0d/%b",
                             k, radr[k], rwide[k], a, wide);
                end
                if (w && !wide) begin
                    vectors++;
                    if (rd8o[k] !== exp_b) begin
                        miss++;
                        $display("FAIL reg_dat8 dut%0d: got %02h expected %02h", k, rd8o[k], exp_b);
                    end
                end
                if (w && wide) begin
                    vectors++;
                    if (rd32o[k] !== d) begin
                        miss++;
                        $display("FAIL reg_dat32 dut%0d: got %08h expected %08h", k, rd32o[k], d);
                    end
                end
            end
            @(posedge clk); #1;
            if (c + 1 == drop || c == last) begin
                cyc[k] = 1'b0; stb[k] = 1'b0;
            end
        end
        if (valid) begin
            if (!w)        prev_rd[k] = exp_rd;
            else if (wide) mem32[a]   = d;
            else           mem8[a]    = exp_b;
        end
    endtask

    task automatic idle_check(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                vectors++;
                if ({ack[k], err[k], rwe[k], rre[k]} !== 4'b0000) begin
                    miss++;
                    $display("FAIL idle dut%0d: ack/err/we/re got %b expected 0000",
                             k, {ack[k], err[k], rwe[k], rre[k]});
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input int k, input string tag);
        logic [113:0] got;
        got = {dato[k], ack[k], err[k], radr[k], rwe[k], rre[k], rwide[k], rd8o[k], rd32o[k]};
        vectors++;
        if (got !== '0) begin
            miss++;
            $display("FAIL %s dut%0d: outputs got %029h expected 0", tag, k, got);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) check_all_zero(k, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle_check(2);
    endtask

    task automatic test_directed();
        run_xfer(0, 1'b1, 5'd3, 4'b0100, 32'h00AB0000, -1);
        mem8[7] = 8'h5A;
        run_xfer(0, 1'b0, 5'd7, 4'b0010, 32'h0, -1);
        mem32[9] = 32'h12345678;
        run_xfer(0, 1'b0, 5'd9, 4'b1111, 32'h0, -1);
        run_xfer(0, 1'b1, 5'd4, 4'b0011, 32'hDEADBEEF, -1);
        idle_check(1);
    endtask

    task automatic test_wait_states();
        mem8[12] = 8'hC3;
        run_xfer(1, 1'b0, 5'd12, 4'b1000, 32'h0, -1);
        run_xfer(1, 1'b1, 5'd13, 4'b1111, 32'hCAFEF00D, -1);
        run_xfer(1, 1'b0, 5'd13, 4'b1111, 32'h0, -1);
        idle_check(1);
    endtask

    task automatic test_abort();
        run_xfer(2, 1'b0, 5'd5, 4'b0001, 32'h0, 3);
        idle_check(2);
        run_xfer(2, 1'b0, 5'd6, 4'b0100, 32'h0, -1);
        run_xfer(0, 1'b1, 5'd8, 4'b0001, 32'h000000EE, 1);
        run_xfer(0, 1'b0, 5'd8, 4'b0001, 32'h0, -1);
        idle_check(1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < N; k++) begin
            run_xfer(k, 1'b1, 5'd20, 4'b0010, 32'h00007700, -1);
            run_xfer(k, 1'b0, 5'd20, 4'b0010, 32'h0, -1);
            run_xfer(k, 1'b0, 5'd21, 4'b0110, 32'h0, -1);
            run_xfer(k, 1'b0, 5'd21, 4'b1111, 32'h0, -1);
        end
        idle_check(1);
    endtask

    task automatic test_reset_mid();
        logic [4:0] a;
        a = 5'd17;
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; adr[2] = a; sel[2] = 4'b1111; dat[2] = '0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_all_zero(2, "async_reset");
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) prev_rd[k] = '0;
        @(posedge clk); #1;
        idle_check(10);
        run_xfer(2, 1'b0, a, 4'b1111, 32'h0, -1);
        idle_check(1);
    endtask

    task automatic test_random();
        int         r, drop;
        logic [3:0] s;
        for (int k = 0; k < N; k++) begin
            for (int t = 0; t < 30; t++) begin
                r = $urandom_range(0, 9);
                if (r < 4)      s = 4'(1 << r);
                else if (r < 7) s = 4'hF;
                else            s = bad_sel[$urandom_range(0, 10)];
                drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, ws_of(k) + 3)) : -1;
                run_xfer(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), s, $urandom, drop);
                if ($urandom_range(0, 2) == 0) idle_check(int'($urandom_range(1, 2)));
            end
        end
        idle_check(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bad_sel = '{4'h0, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        for (int i = 0; i < 32; i++) begin
            mem8[i]  = 8'($urandom);
            mem32[i] = $urandom;
        end
        for (int k = 0; k < N; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            adr[k] = '0; sel[k] = '0; dat[k] = '0; prev_rd[k] = '0;
        end
        test_reset();
        test_directed();
        test_wait_states();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
